// File: rtl/sample_frame_packer.sv
// Snapshot NUM_CH channels + sample counter per tick into a frame, buffer in a
// FWFT word FIFO, stream out over valid/ready with end-of-frame marker.
// Ports: clk_i, reset (sync, active-high), tick_i, ch_i, counter_i,
//        m_data_o/m_valid_o/m_ready_i/m_last_o, level_o, drop_cnt_o, busy_o.
// Optional: SAMPLE_FRAME_PACKER_CHECKSUM_EN appends an XOR checksum word.
`timescale 1ns/1ps
module sample_frame_packer #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic                          tick_i,
  input  logic [NUM_CH*32-1:0]          ch_i,
  input  logic [31:0]                   counter_i,
  output logic [31:0]                   m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          m_last_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [15:0]                   drop_cnt_o,
  output logic                          busy_o
);

`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
  localparam int L = NUM_CH + 2;
`else
  localparam int L = NUM_CH + 1;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state;
  logic [5:0]              idx;
  logic [31:0]             hdr_q;
  logic [NUM_CH-1:0][31:0] ch_q;
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
  logic [31:0]             csum_q;
`endif

  logic [32:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          wr_en;
  logic          wr_last;
  logic [31:0]   wr_data;
  logic          free_ok;
  logic          drop_ev;
  logic          pop;
  logic [CW-1:0] rem;
  logic [PW-1:0] nxt;

  assign wr_en   = (state == WRITE);
  assign wr_last = (idx == 6'(L - 1));
  assign free_ok = (CW'(FIFO_DEPTH) - count) >= CW'(L);
  assign drop_ev = tick_i && ((state == WRITE) || !free_ok);
  assign level_o = count;

  always_comb begin
    wr_data = hdr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == 6'(k + 1)) wr_data = ch_q[k];
    end
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
    if (wr_last) wr_data = csum_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      busy_o <= 1'b0;
      hdr_q  <= '0;
      ch_q   <= '0;
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // Whole-frame space is reserved here, so WRITE never stalls.
          if (tick_i && free_ok) begin
            hdr_q  <= counter_i;
            ch_q   <= ch_i;
            idx    <= '0;
            state  <= WRITE;
            busy_o <= 1'b1;
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        WRITE: begin
          idx <= idx + 6'd1;
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
          csum_q <= csum_q ^ wr_data;
`endif
          if (wr_last) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      drop_cnt_o <= '0;
    end else if (drop_ev && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset && wr_en) mem[wr_ptr] <= {wr_last, wr_data};
  end

  // The head word stays in mem (and in count) until accepted; the
  // output register is a copy, refilled from mem or bypassed from the
  // writer when mem holds nothing beyond the departing head.
  assign pop = m_valid_o && m_ready_i;
  assign rem = count - CW'(pop);
  assign nxt = pop ? (rd_ptr + PW'(1)) : rd_ptr;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (pop || !m_valid_o) begin
        if (rem != '0) begin
          {m_last_o, m_data_o} <= mem[nxt];
          m_valid_o            <= 1'b1;
        end else if (wr_en) begin
          m_last_o  <= wr_last;
          m_data_o  <= wr_data;
          m_valid_o <= 1'b1;
        end else begin
          m_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_packer.sv
// Self-checking bench for sample_frame_packer: frame-level reference model,
// randomized data/ready, scenario tasks, scoreboard monitor.
`timescale 1ns/1ps
module tb_sample_frame_packer;

  localparam int NUM_CH = 8;
  localparam int DEPTH  = 64;
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
  localparam int L      = NUM_CH + 2;
  localparam int EXP_LVL = 60;
  localparam int EXP_DRP = 2;
  localparam int EXP_FR  = 6;
`else
  localparam int L      = NUM_CH + 1;
  localparam int EXP_LVL = 63;
  localparam int EXP_DRP = 1;
  localparam int EXP_FR  = 7;
`endif

  logic                   clk_i = 1'b0;
  logic                   reset = 1'b1;
  logic                   tick_i = 1'b0;
  logic [NUM_CH*32-1:0]   ch_i = '0;
  logic [31:0]            counter_i = '0;
  logic [31:0]            m_data_o;
  logic                   m_valid_o;
  logic                   m_ready_i = 1'b0;
  logic                   m_last_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [15:0]            drop_cnt_o;
  logic                   busy_o;

  sample_frame_packer #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset(reset), .tick_i(tick_i), .ch_i(ch_i),
    .counter_i(counter_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .level_o(level_o),
    .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  int          last_cap = -100;
  logic [15:0] exp_drop = '0;
  int          frames_seen = 0;

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [32:0] pw = '0;
  logic [32:0] w;

  always @(negedge clk_i) begin
    if (!reset) begin
      if (pv && !pr) begin
        checks++;
        if (m_valid_o !== 1'b1 || {m_last_o, m_data_o} !== pw) begin
          failures++;
          $display("FAIL hold: got v=%b %h want v=1 %h",
                   m_valid_o, {m_last_o, m_data_o}, pw);
        end
      end
      if (m_valid_o && m_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %h want none",
                   {m_last_o, m_data_o});
        end else begin
          w = exp_q.pop_front();
          if ({m_last_o, m_data_o} !== w) begin
            failures++;
            $display("FAIL word: got %h want %h",
                     {m_last_o, m_data_o}, w);
          end
          if (m_last_o) frames_seen++;
        end
      end
    end
    pv = reset ? 1'b0 : m_valid_o;
    pr = m_ready_i;
    pw = {m_last_o, m_data_o};
  end

  function automatic logic [NUM_CH*32-1:0] rand_ch();
    logic [NUM_CH*32-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Frame-level model: a tick is taken only if the previous frame is
  // completely written and the whole frame fits; else it is dropped.
  task automatic model_capture(input logic [31:0] c,
                               input logic [NUM_CH*32-1:0] d);
    logic [31:0] x;
    logic [31:0] wd;
    if ((cyc - last_cap >= L + 1) && (DEPTH - exp_q.size() >= L)) begin
      last_cap = cyc;
      x = c;
      exp_q.push_back({1'b0, c});
      for (int k = 0; k < NUM_CH; k++) begin
        wd = d[k*32 +: 32];
        x  = x ^ wd;
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
        exp_q.push_back({1'b0, wd});
`else
        exp_q.push_back({(k == NUM_CH - 1), wd});
`endif
      end
`ifdef SAMPLE_FRAME_PACKER_CHECKSUM_EN
      exp_q.push_back({1'b1, x});
`endif
    end else if (exp_drop != 16'hFFFF) begin
      exp_drop++;
    end
  endtask

  task automatic drive(input bit t, input logic [31:0] c,
                       input logic [NUM_CH*32-1:0] d);
    @(posedge clk_i);
    #1;
    tick_i    = t;
    counter_i = c;
    ch_i      = d;
    if (t) model_capture(c, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom, rand_ch());
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_drop    = '0;
    last_cap    = -100;
    frames_seen = 0;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset  = 1'b1;
    tick_i = 1'b0;
    clear_model();
    @(posedge clk_i);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int i;
    m_ready_i = 1'b1;
    i = 0;
    while (i < 600 && (exp_q.size() != 0 || m_valid_o || busy_o)) begin
      idle(1);
      i++;
    end
    checks++;
    if (exp_q.size() != 0 || m_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout: left=%0d valid=%b want 0 0",
               exp_q.size(), m_valid_o);
    end
    checks++;
    if (level_o !== '0) begin
      failures++;
      $display("FAIL drain_level: got %0d want 0", level_o);
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #1;
    reset     = 1'b1;
    tick_i    = 1'b1;
    m_ready_i = 1'b1;
    counter_i = $urandom;
    ch_i      = rand_ch();
    clear_model();
    @(posedge clk_i);
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== '0) begin
      failures++;
      $display("FAIL reset_out: got v=%b l=%b d=%h want 0 0 0",
               m_valid_o, m_last_o, m_data_o);
    end
    checks++;
    if (level_o !== '0 || drop_cnt_o !== '0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stat: got lvl=%0d drop=%0d busy=%b want 0 0 0",
               level_o, drop_cnt_o, busy_o);
    end
    tick_i = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [NUM_CH*32-1:0] d;
    logic [31:0]          lastw;
    do_reset();
    m_ready_i = 1'b1;
    lastw = 32'h0000_0005;
    for (int k = 0; k < NUM_CH; k++) begin
      d[k*32 +: 32] = 32'h1000_0000 + k;
      lastw = lastw ^ (32'h1000_0000 + k);
    end
`ifndef SAMPLE_FRAME_PACKER_CHECKSUM_EN
    lastw = 32'h1000_0000 + NUM_CH - 1;
`endif
    drive(1'b1, 32'h0000_0005, d);
    idle(1);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: got %b want 1", busy_o);
    end
    idle(1);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h5 || m_last_o !== 1'b0) begin
      failures++;
      $display("FAIL single_first: got v=%b d=%h l=%b want 1 5 0",
               m_valid_o, m_data_o, m_last_o);
    end
    idle(L - 1);
    checks++;
    if (m_valid_o !== 1'b1 || m_last_o !== 1'b1 || m_data_o !== lastw) begin
      failures++;
      $display("FAIL single_last: got v=%b l=%b d=%h want 1 1 %h",
               m_valid_o, m_last_o, m_data_o, lastw);
    end
    drain();
    checks++;
    if (frames_seen != 1) begin
      failures++;
      $display("FAIL single_frames: got %0d want 1", frames_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_CH*32-1:0] d;
    do_reset();
    m_ready_i = 1'b0;
    for (int k = 0; k < NUM_CH; k++) d[k*32 +: 32] = 32'h1000_0000 + k;
    drive(1'b1, 32'h0000_0005, d);
    idle(L + 2);
    idle(20);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h5 || level_o !== L) begin
      failures++;
      $display("FAIL bp_hold: got v=%b d=%h lvl=%0d want 1 5 %0d",
               m_valid_o, m_data_o, level_o, L);
    end
    drain();
    checks++;
    if (frames_seen != 1) begin
      failures++;
      $display("FAIL bp_frames: got %0d want 1", frames_seen);
    end
  endtask

  task automatic test_tick_during_write();
    do_reset();
    m_ready_i = 1'b1;
    drive(1'b1, $urandom, rand_ch());
    idle(2);
    drive(1'b1, $urandom, rand_ch());
    idle(1);
    checks++;
    if (drop_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL tdw_drop: got %0d want 1", drop_cnt_o);
    end
    drain();
    checks++;
    if (frames_seen != 1) begin
      failures++;
      $display("FAIL tdw_frames: got %0d want 1", frames_seen);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_ready_i = 1'b0;
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, $urandom, rand_ch());
      idle(11);
    end
    checks++;
    if (level_o !== EXP_LVL) begin
      failures++;
      $display("FAIL full_level: got %0d want %0d", level_o, EXP_LVL);
    end
    checks++;
    if (drop_cnt_o !== EXP_DRP) begin
      failures++;
      $display("FAIL full_drop: got %0d want %0d", drop_cnt_o, EXP_DRP);
    end
    drain();
    checks++;
    if (frames_seen != EXP_FR) begin
      failures++;
      $display("FAIL full_frames: got %0d want %0d", frames_seen, EXP_FR);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    m_ready_i = 1'b1;
    drive(1'b1, $urandom, rand_ch());
    drive(1'b1, $urandom, rand_ch());
    idle(2);
    @(posedge clk_i);
    #1;
    reset  = 1'b1;
    tick_i = 1'b0;
    clear_model();
    @(posedge clk_i);
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || level_o !== '0 ||
        busy_o !== 1'b0 || drop_cnt_o !== '0) begin
      failures++;
      $display("FAIL rmf_state: got v=%b lvl=%0d busy=%b drop=%0d want 0 0 0 0",
               m_valid_o, level_o, busy_o, drop_cnt_o);
    end
    reset = 1'b0;
    drive(1'b1, $urandom, rand_ch());
    drain();
    checks++;
    if (frames_seen != 1) begin
      failures++;
      $display("FAIL rmf_frames: got %0d want 1", frames_seen);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 5) == 0), $urandom, rand_ch());
      m_ready_i = ($urandom_range(0, 2) != 0);
    end
    drain();
    checks++;
    if (drop_cnt_o !== exp_drop) begin
      failures++;
      $display("FAIL rand_drop: got %0d want %0d", drop_cnt_o, exp_drop);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready_i = 1'b0;
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, $urandom, rand_ch());
      idle(11);
    end
    for (int i = 0; i < 65540; i++) drive(1'b1, $urandom, 32'h0);
    idle(1);
    checks++;
    if (drop_cnt_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_drop: got %h want ffff", drop_cnt_o);
    end
    drain();
    checks++;
    if (frames_seen != EXP_FR) begin
      failures++;
      $display("FAIL sat_frames: got %0d want %0d", frames_seen, EXP_FR);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_tick_during_write();
    test_fifo_full();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
